imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time writer for the pipeline CPU's instruction memory. It takes a framed byte stream from the UART receiver through a valid/ready handshake and packs big-endian bytes into 32-bit instructions. Each instruction goes to the instruction-RAM write port at word-aligned byte addresses. It holds the CPU in reset until a complete, checksum-verified image has been written.

Parameters:
ADDR_WIDTH, 8, word-index width; capacity 2^ADDR_WIDTH words, matching Address[9:2] decode of the instruction memory
MAX_WORDS, 2**ADDR_WIDTH, largest accepted image length in words

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin a load; ignored while busy=1
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte this cycle
imem_we  output  1  instruction-RAM write strobe, one cycle per word
imem_addr  output  32  byte address of write, bits[1:0]=0
imem_wdata  output  32  instruction word
word_count  output  16  words written so far in current load
busy  output  1  load in progress
done  output  1  last load completed with good checksum, sticky
error  output  1  last load failed, sticky
cpu_hold  output  1  hold pipeline CPU in reset

Behaviour:
- Reset (async, rst_n=0): state IDLE. rx_ready, imem_we, busy, done, error and cpu_hold are 0. imem_addr, imem_wdata and word_count are 0. Byte-lane counter, word index and checksum accumulator are cleared. Reset mid-load abandons the frame; words already written stay in RAM.
- Frame format: LEN_HI, LEN_LO (N = 16-bit word count), then 4*N payload bytes with the MSB of each word first, then one CHK byte. CHK = 8-bit sum mod 256 of all payload bytes; the header is excluded.
- Byte accepted when rx_valid & rx_ready. At most one byte per cycle. rx_ready is combinational from state only: 1 in HDR_HI, HDR_LO, DATA and CHECK; 0 elsewhere.
- IDLE, DONE, ERROR + start: clear done, error, word_count, lane and checksum. Set busy=1 and cpu_hold=1. Go to HDR_HI.
- HDR_HI: on accept, latch N[15:8]; go to HDR_LO.
- HDR_LO: on accept, latch N[7:0], then evaluate the length on the next cycle in LEN_CHK:
  - N=0 or N>MAX_WORDS: go to ERROR. No writes occur.
  - Otherwise: go to DATA.
- DATA:
  - Each accepted byte shifts into the word register, MSB first, and adds to the checksum. The lane counter runs 0..3.
  - On the lane-3 accept: next cycle imem_we=1, imem_addr={word_idx,2'b00} zero-extended, imem_wdata=assembled word. word_idx and word_count increment in that same cycle. Write latency is 1 cycle after the 4th byte.
  - rx_ready stays 1 during the write cycle; back-to-back bytes are legal.
  - After word N is accepted, go to CHECK.
- CHECK: on accept, compare the byte to the checksum.
  - Equal: go to DONE; done=1, busy=0, cpu_hold=0.
  - Not equal: go to ERROR; error=1, busy=0, cpu_hold stays 1.
- DONE, ERROR: rx_ready=0; flags hold until the next start. start in ERROR retries the load.
- imem_we is 0 in every cycle except the write cycle. imem_addr and imem_wdata hold their last written values otherwise.
- start while busy=1: ignored. Unsolicited rx bytes in IDLE, DONE or ERROR are not consumed (rx_ready=0).
- word_idx width ADDR_WIDTH+1, so N=MAX_WORDS writes address (MAX_WORDS-1)*4 without wrap.

Decomposition:
- Package imem_loader_pkg holds:
  - State enum: IDLE, HDR_HI, HDR_LO, LEN_CHK, DATA, CHECK, DONE, ERROR.
  - Constants: BYTES_PER_WORD=4, HDR_BYTES=2.
  - Frame-length limit helper.
- One sub-module, imem_byte_packer: lane counter, shift register and word_ready pulse. The FSM, checksum and address logic stay in imem_loader.

Test Plan:
- Good 2-word load: send 00 02 24 1D 01 00 24 04 00 00 6A. Expect imem_we pulses with (addr 0x0, data 0x241d0100) and (addr 0x4, data 0x24040000). Then word_count=2, done=1, cpu_hold=0.
- Bad checksum: same frame with CHK=6B. Expect both writes to occur, then error=1, done=0, cpu_hold=1. A following start plus the correct frame gives done=1.
- Length limits: N=0 gives error with no imem_we. N=257 with ADDR_WIDTH=8 gives error with no writes. N=256 gives a last write at addr 0x3FC.
- Backpressure and gaps: toggle rx_valid randomly. The assembled words are unchanged, with exactly one imem_we per word. rx_ready=0 in IDLE, so a byte offered there is not consumed.
- Reset mid-payload: assert rst_n=0 after 6 payload bytes. All outputs go to 0 immediately. A restart loads a clean image from addr 0.
- start pulsed in DATA: no effect. The frame completes normally with done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        LEN_CHK,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    // A frame is loadable only if it carries at least one word and fits in the RAM.
    function automatic logic frame_len_ok(input logic [15:0] n, input int max_words);
        return (n != 16'd0) && (int'({16'd0, n}) <= max_words);
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words, MSB first.
// Latency: word_rdy/word_dat are combinational with the 4th byte of a word.
// Backpressure: none; advances only on byte_vld, the caller owns the handshake.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_rdy,
    output logic [31:0] word_dat
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);

    logic [LANE_W-1:0] lane;
    logic [23:0]       shift_dat;

    // The current byte completes the word in flight; present it without waiting a cycle
    // so the loader can register the RAM write on the very next edge.
    assign word_rdy = byte_vld && (lane == LAST_LANE);
    assign word_dat = {shift_dat, byte_dat};

    // Lane counter wraps 0..3; older bytes simply shift out, so no per-word clear is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane      <= '0;
            shift_dat <= '0;
        end else if (clear) begin
            lane      <= '0;
            shift_dat <= '0;
        end else if (byte_vld) begin
            lane      <= lane + LANE_ONE;
            shift_dat <= {shift_dat[15:0], byte_dat};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed UART bytes -> checksum-verified instruction-RAM image, CPU held until good.
// Latency: RAM write strobe one cycle after the 4th byte of each word; flags one cycle after CHK.
// Backpressure: rx_ready is a pure function of state, high in HDR_HI/HDR_LO/DATA/CHECK only.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 2**ADDR_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    // One extra index bit so a full-capacity image ends at the top word without wrapping.
    localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH + 1)'(1);

    state_t              state;
    logic [15:0]         frame_len;
    logic [ADDR_WIDTH:0] word_idx;
    logic [7:0]          chk_acc;

    logic                accept;
    logic                data_acc;
    logic                start_ok;
    logic                word_rdy;
    logic [31:0]         word_dat;
    logic                last_word;

    // Only the byte-consuming states can take a byte; nothing else influences ready.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            HDR_HI, HDR_LO, DATA, CHECK: rx_ready = 1'b1;
            default:                     rx_ready = 1'b0;
        endcase
    end

    assign accept    = rx_valid && rx_ready;
    assign data_acc  = accept && (state == DATA);
    assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign last_word = (word_count + 16'd1) == frame_len;

    imem_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok),
        .byte_vld (data_acc),
        .byte_dat (rx_data),
        .word_rdy (word_rdy),
        .word_dat (word_dat)
    );

    // Frame sequencer: header, length gate, payload writes with running checksum, verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_len  <= '0;
            word_idx   <= '0;
            chk_acc    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; address/data registers hold their last value.
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
                        word_idx   <= '0;
                        chk_acc    <= '0;
                        frame_len  <= '0;
                        busy       <= 1'b1;
                        cpu_hold   <= 1'b1;
                        state      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        frame_len[15:8] <= rx_data;
                        state           <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        frame_len[7:0] <= rx_data;
                        state          <= LEN_CHK;
                    end
                end
                LEN_CHK: begin
                    // Reject empty or oversize images before any RAM word is touched.
                    if (frame_len_ok(frame_len, MAX_WORDS)) begin
                        state <= DATA;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        chk_acc <= chk_acc + rx_data;
                        if (word_rdy) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= {{(29 - ADDR_WIDTH){1'b0}}, word_idx, 2'b00};
                            imem_wdata <= word_dat;
                            word_idx   <= word_idx + IDX_ONE;
                            word_count <= word_count + 16'd1;
                            if (last_word) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (rx_data == chk_acc) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            // CPU stays in reset: a partially trusted image must never run.
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a frame-level reference model and write scoreboard.
// Latency: expected writes queued as each word's last byte is handed over, checked on the strobe.
// Backpressure: random rx_valid gaps; bytes are held until rx_ready is seen.
module tb_imem_loader;

    localparam int AW   = 8;
    localparam int MAXW = 2**AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img [0:MAXW-1];
    int          vectors = 0;
    int          miscompares = 0;
    int          gap_max = 2;
    bit          abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: imem_we=1 addr %h data %h, no write expected", imem_addr, imem_wdata);
            end else begin
                vectors--;
                mon_e = exp_q.pop_front();
                check("wr_addr", imem_addr, mon_e.addr);
                check("wr_data", imem_wdata, mon_e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_zero(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (abort) return;
        @(negedge clk);
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_ready_timeout: byte %h not taken, rx_ready=%b expected 1", b, rx_ready);
            abort = 1'b1;
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_not_busy(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_clear"}, busy, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: a frame of n words loads only if 1<=n<=MAXW; words land at 4*i;
    // done only if the trailing byte equals the payload byte sum mod 256.
    task automatic run_load(input string tag, input int n, input bit corrupt,
                            input int start_at, input int reset_at);
        logic [15:0] n16;
        logic [7:0]  sum;
        logic [7:0]  b;
        int          k;
        bit          len_ok;
        bit          good;
        n16    = 16'(n);
        sum    = 8'h00;
        k      = 0;
        abort  = 1'b0;
        len_ok = (n >= 1) && (n <= MAXW);
        good   = len_ok && !corrupt;
        pulse_start();
        check({tag, "_busy_set"}, busy, 1);
        check({tag, "_hold_set"}, cpu_hold, 1);
        send_byte(n16[15:8]);
        send_byte(n16[7:0]);
        if (len_ok) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 4; j++) begin
                    b = img[i][31-8*j -: 8];
                    if (k == reset_at) begin
                        do_reset(tag);
                        return;
                    end
                    if (k == start_at) pulse_start();
                    send_byte(b);
                    sum = sum + b;
                    k++;
                    if (j == 3 && !abort) exp_q.push_back({32'(i * 4), img[i]});
                end
            end
            send_byte(corrupt ? sum + 8'd1 : sum);
        end
        wait_not_busy(tag);
        check({tag, "_done"}, done, 32'(good));
        check({tag, "_error"}, error, 32'(!good));
        check({tag, "_cpu_hold"}, cpu_hold, 32'(!good));
        check({tag, "_word_count"}, word_count, len_ok ? 32'(n) : 32'd0);
        check({tag, "_rx_ready_idle"}, rx_ready, 0);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        if (len_ok) check({tag, "_last_addr"}, imem_addr, 32'((n - 1) * 4));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // A byte offered before any start must not be taken.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check("idle_rx_ready", rx_ready, 0);
        end
        rx_valid = 1'b0;

        img[0] = 32'h241D0100;
        img[1] = 32'h24040000;
        run_load("good2", 2, 1'b0, -1, -1);
        run_load("badchk", 2, 1'b1, -1, -1);
        run_load("retry", 2, 1'b0, -1, -1);

        run_load("len0", 0, 1'b0, -1, -1);
        run_load("len257", 257, 1'b0, -1, -1);

        gap_max = 1;
        for (int i = 0; i < MAXW; i++) img[i] = $urandom;
        run_load("len256", 256, 1'b0, -1, -1);

        gap_max = 3;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) img[i] = $urandom;
            run_load("rand", int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), -1, -1);
        end

        for (int i = 0; i < 4; i++) img[i] = $urandom;
        run_load("rst_mid", 4, 1'b0, -1, 6);
        run_load("after_rst", 4, 1'b0, -1, -1);

        for (int i = 0; i < 3; i++) img[i] = $urandom;
        run_load("start_in_data", 3, 1'b0, 5, -1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
